bus_keeper_mux: RTL and testbench
=================================

# bus_keeper_mux

Parametrised, registered successor to the datapath bus multiplexer: selects one of NUM_SOURCES register outputs onto the shared CPU bus from one-hot drive enables and registers the result. It detects contention (multiple drivers) and idle cycles, and either holds the last driven value (bus keeper) or drives a fixed idle value. Contention events are logged in a sticky flag and a saturating counter for debug. It sits between the register file/special registers and the bus, replacing the external 32-to-5 encoder plus combinational mux.

## Interface
- DATA_WIDTH, 32, bus width in bits
- NUM_SOURCES, 24, number of bus sources (2..32)
- SRC_W, $clog2(NUM_SOURCES), width of the source index
- KEEP_ON_IDLE, 1, 1: hold last value when no driver; 0: drive IDLE_VALUE
- IDLE_VALUE, {DATA_WIDTH{1'b1}}, reset value of bus_out; idle value when KEEP_ON_IDLE=0
- ERR_CNT_W, 8, contention counter width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- drive_en  in  NUM_SOURCES  one-hot drive request; bit i = source i "out" signal
- bus_in  in  NUM_SOURCES*DATA_WIDTH  flattened sources; source i at [i*DATA_WIDTH +: DATA_WIDTH]
- clear_err  in  1  synchronous clear of err_sticky and err_count
- bus_out  out  DATA_WIDTH  registered bus value
- bus_src  out  SRC_W  index of the source captured into bus_out
- bus_valid  out  1  high when bus_out was loaded from a source in the previous cycle
- contention  out  1  one-cycle pulse: >1 drive_en bit was set in the previous cycle
- err_sticky  out  1  set on any contention, held until clear_err
- err_count  out  ERR_CNT_W  saturating count of contention cycles

## Operation
- Every cycle, classify drive_en: NONE (all 0), SINGLE (exactly 1 bit), MULTI (≥2 bits).
- SINGLE: bus_out <= bus_in[i]; bus_src <= i; bus_valid <= 1; contention <= 0.
- MULTI: lowest set index i wins and is loaded as in SINGLE. In addition, bus_valid <= 1, contention <= 1, err_sticky <= 1, and err_count increments.
- NONE: bus_valid <= 0; contention <= 0; bus_src holds.
  - KEEP_ON_IDLE=1: bus_out holds.
  - KEEP_ON_IDLE=0: bus_out <= IDLE_VALUE.
- err_count saturates at 2^ERR_CNT_W-1; no wrap.
- clear_err without contention in the same cycle: err_sticky <= 0, err_count <= 0.
- clear_err together with MULTI: the new event wins. err_sticky <= 1, err_count <= 1.
- Sources at index ≥ NUM_SOURCES do not exist. drive_en has exactly NUM_SOURCES bits, so there is no invalid-select case.

## Timing
- Latency: 1 clock from drive_en/bus_in sampling to bus_out, bus_src, bus_valid and contention.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset (async assert, sync to next edge on release) sets:
  - bus_out = IDLE_VALUE, bus_src = 0
  - bus_valid = 0, contention = 0
  - err_sticky = 0, err_count = 0
- Reset asserted mid-transfer: all outputs go to reset values immediately, without waiting for a clock edge. The first edge after release samples drive_en normally.
- Back-to-back drivers on consecutive cycles give consecutive bus_out updates; there are no bubbles.
- contention is a pulse; it is not held across idle cycles.

## Test plan
- Reset: hold reset_n=0 with random inputs, then release -> bus_out=IDLE_VALUE (0xFFFFFFFF), bus_src=0, bus_valid=0, err_count=0 until the first driven edge.
- Single drive: bus_in[5]=0x12345678, drive_en=1<<5 for one cycle -> next cycle bus_out=0x12345678, bus_src=5, bus_valid=1, contention=0.
- Idle keep: after the previous step, drive_en=0 for 3 cycles.
  - KEEP_ON_IDLE=1 -> bus_out stays 0x12345678, bus_valid=0.
  - KEEP_ON_IDLE=0 -> bus_out=0xFFFFFFFF.
- Contention: drive_en bits 3 and 9 set, bus_in[3]=0xA, bus_in[9]=0xB -> bus_out=0xA, bus_src=3, contention pulse=1, err_sticky=1, err_count=1.
- Saturation and clear:
  - ERR_CNT_W=2, 5 contention cycles -> err_count=3.
  - clear_err alone -> err_count=0, err_sticky=0.
  - clear_err together with contention -> err_count=1, err_sticky=1.
- Async reset mid-stream: assert reset_n between edges while drive_en is active -> outputs reset without a clock edge. Release -> normal capture resumes on the next edge.

Source files
------------

// File: rtl/bus_keeper_mux.sv
// Registered bus multiplexer with bus-keeper/idle-value behaviour and contention logging.
// Lowest-index driver wins when several drive enables are asserted together.
module bus_keeper_mux #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    NUM_SOURCES  = 24,
  parameter int                    SRC_W        = $clog2(NUM_SOURCES),
  parameter int                    KEEP_ON_IDLE = 1,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE   = {DATA_WIDTH{1'b1}},
  parameter int                    ERR_CNT_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_SOURCES-1:0]            drive_en,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] bus_in,
  input  logic                              clear_err,
  output logic [DATA_WIDTH-1:0]             bus_out,
  output logic [SRC_W-1:0]                  bus_src,
  output logic                              bus_valid,
  output logic                              contention,
  output logic                              err_sticky,
  output logic [ERR_CNT_W-1:0]              err_count
);

  logic [DATA_WIDTH-1:0] src_data [NUM_SOURCES];
  logic [DATA_WIDTH-1:0] sel_data;
  logic [SRC_W-1:0]      sel_idx;
  logic                  any_drive;
  logic                  multi_drive;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      assign src_data[gi] = bus_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign any_drive = |drive_en;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_drive = |(drive_en & (drive_en - NUM_SOURCES'(1)));

  always_comb begin
    sel_idx  = '0;
    sel_data = src_data[0];
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (drive_en[i]) begin
        sel_idx  = SRC_W'(i);
        sel_data = src_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_out    <= IDLE_VALUE;
      bus_src    <= '0;
      bus_valid  <= 1'b0;
      contention <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      if (any_drive) begin
        bus_out   <= sel_data;
        bus_src   <= sel_idx;
        bus_valid <= 1'b1;
      end else begin
        bus_valid <= 1'b0;
        if (KEEP_ON_IDLE == 0) begin
          bus_out <= IDLE_VALUE;
        end
      end
      contention <= multi_drive;
      // A contention event in the same cycle as clear_err counts as the first new event.
      if (multi_drive) begin
        err_sticky <= 1'b1;
        if (clear_err) begin
          err_count <= ERR_CNT_W'(1);
        end else if (!(&err_count)) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
      end else if (clear_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_keeper_mux.sv
// Scoreboard bench for bus_keeper_mux: one keep-on-idle instance with a wide counter and
// one idle-value instance with a 2-bit counter share the same stimulus.
module tb_bus_keeper_mux;
  localparam int NS = 24;
  localparam int DW = 32;

  logic              clk;
  logic              reset_n;
  logic [NS-1:0]     drive_en;
  logic [NS*DW-1:0]  bus_in;
  logic              clear_err;

  logic [DW-1:0] out_a, out_b;
  logic [4:0]    src_a, src_b;
  logic          valid_a, valid_b, cont_a, cont_b, sticky_a, sticky_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  bus_keeper_mux #(.DATA_WIDTH(DW), .NUM_SOURCES(NS), .KEEP_ON_IDLE(1), .ERR_CNT_W(8)) u_keep (
    .clk(clk), .reset_n(reset_n), .drive_en(drive_en), .bus_in(bus_in), .clear_err(clear_err),
    .bus_out(out_a), .bus_src(src_a), .bus_valid(valid_a), .contention(cont_a),
    .err_sticky(sticky_a), .err_count(cnt_a)
  );

  bus_keeper_mux #(.DATA_WIDTH(DW), .NUM_SOURCES(NS), .KEEP_ON_IDLE(0), .ERR_CNT_W(2)) u_idle (
    .clk(clk), .reset_n(reset_n), .drive_en(drive_en), .bus_in(bus_in), .clear_err(clear_err),
    .bus_out(out_b), .bus_src(src_b), .bus_valid(valid_b), .contention(cont_b),
    .err_sticky(sticky_b), .err_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tgt;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  src;
    logic        valid;
    logic        cont;
    logic        sticky;
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state, derived from the rules: lowest driver wins, counters saturate.
  logic [31:0] m_out_a, m_out_b;
  logic [4:0]  m_src;
  logic        m_valid, m_cont, m_sticky;
  int          m_cnt_a, m_cnt_b;
  logic [NS*DW-1:0] bus_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out_a = 32'hFFFF_FFFF;
    m_out_b = 32'hFFFF_FFFF;
    m_src = 0; m_valid = 0; m_cont = 0; m_sticky = 0;
    m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_update(input logic [NS-1:0] de, input logic clr);
    int n = 0;
    int idx = 0;
    for (int i = 0; i < NS; i++) begin
      if (de[i]) begin
        if (n == 0) idx = i;
        n++;
      end
    end
    if (n >= 1) begin
      m_out_a = bus_next[idx*DW +: DW];
      m_out_b = bus_next[idx*DW +: DW];
      m_src   = 5'(idx);
      m_valid = 1;
    end else begin
      m_valid = 0;
      m_out_b = 32'hFFFF_FFFF;
    end
    m_cont = (n >= 2);
    if (n >= 2) begin
      m_sticky = 1;
      if (clr) begin
        m_cnt_a = 1; m_cnt_b = 1;
      end else begin
        m_cnt_a = (m_cnt_a + 1 > 255) ? 255 : m_cnt_a + 1;
        m_cnt_b = (m_cnt_b + 1 > 3) ? 3 : m_cnt_b + 1;
      end
    end else if (clr) begin
      m_sticky = 0; m_cnt_a = 0; m_cnt_b = 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.tgt = cyc + 1;
    e.out_a = m_out_a; e.out_b = m_out_b; e.src = m_src;
    e.valid = m_valid; e.cont = m_cont; e.sticky = m_sticky;
    e.cnt_a = 8'(m_cnt_a); e.cnt_b = 2'(m_cnt_b);
    sb.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [NS-1:0] de, input logic clr);
    @(posedge clk);
    #1;
    reset_n = rst; drive_en = de; clear_err = clr; bus_in = bus_next;
    if (!rst) model_reset();
    else model_update(de, clr);
    push_exp();
  endtask

  task automatic rand_bus();
    for (int i = 0; i < NS; i++) bus_next[i*DW +: DW] = $urandom;
  endtask

  function automatic logic [NS-1:0] rand_de();
    int kind = $urandom_range(0, 9);
    int a = $urandom_range(0, NS - 1);
    int b = (a + 1 + $urandom_range(0, NS - 2)) % NS;
    logic [NS-1:0] v = '0;
    if (kind <= 3) return '0;
    v[a] = 1'b1;
    if (kind <= 7) return v;
    v[b] = 1'b1;
    v = v | (NS'($urandom) & NS'($urandom));
    return v;
  endfunction

  // Monitor: outputs are presented every edge; pop the record aimed at this edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].tgt < cyc) begin
      void'(sb.pop_front());
      n_cmp++; n_bad++;
      $display("FAIL stale_record at cyc %0d: got none expected a check", cyc);
    end else if (sb.size() > 0 && sb[0].tgt == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("out_keep", out_a, e.out_a);
      chk("out_idle", out_b, e.out_b);
      chk("src_keep", {27'd0, src_a}, {27'd0, e.src});
      chk("src_idle", {27'd0, src_b}, {27'd0, e.src});
      chk("valid_keep", {31'd0, valid_a}, {31'd0, e.valid});
      chk("valid_idle", {31'd0, valid_b}, {31'd0, e.valid});
      chk("cont_keep", {31'd0, cont_a}, {31'd0, e.cont});
      chk("cont_idle", {31'd0, cont_b}, {31'd0, e.cont});
      chk("sticky_keep", {31'd0, sticky_a}, {31'd0, e.sticky});
      chk("sticky_idle", {31'd0, sticky_b}, {31'd0, e.sticky});
      chk("cnt_keep", {24'd0, cnt_a}, {24'd0, e.cnt_a});
      chk("cnt_idle", {30'd0, cnt_b}, {30'd0, e.cnt_b});
      $display("cyc %0d: out %h/%h src %0d valid %b cont %b sticky %b cnt %0d/%0d",
               cyc, out_a, out_b, src_a, valid_a, cont_a, sticky_a, cnt_a, cnt_b);
    end
  end

  initial begin
    reset_n = 1'b0; drive_en = '0; clear_err = 1'b0; bus_in = '0; bus_next = '0;
    model_reset();

    // Reset held with random inputs, then release into idle.
    for (int k = 0; k < 3; k++) begin
      rand_bus();
      step(1'b0, rand_de(), 1'($urandom_range(0, 1)));
    end
    bus_next = '0;
    step(1'b1, '0, 1'b0);
    step(1'b1, '0, 1'b0);

    // Single driver, then idle hold / idle value.
    bus_next[5*DW +: DW] = 32'h1234_5678;
    step(1'b1, NS'(1) << 5, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, '0, 1'b0);

    // Contention on sources 3 and 9, then saturation of the 2-bit counter.
    bus_next[3*DW +: DW] = 32'h0000_000A;
    bus_next[9*DW +: DW] = 32'h0000_000B;
    step(1'b1, (NS'(1) << 3) | (NS'(1) << 9), 1'b0);
    step(1'b1, '0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, (NS'(1) << 3) | (NS'(1) << 9), 1'b0);
    step(1'b1, '0, 1'b1);
    step(1'b1, (NS'(1) << 3) | (NS'(1) << 9), 1'b1);
    step(1'b1, '0, 1'b0);

    // Randomized traffic, including back-to-back drivers and occasional clears.
    for (int k = 0; k < 300; k++) begin
      rand_bus();
      step(1'b1, rand_de(), ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset between edges while a driver is active.
    @(posedge clk);
    #1;
    rand_bus();
    bus_in = bus_next;
    drive_en = NS'(1) << 7;
    #2;
    reset_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk("async_out_keep", out_a, 32'hFFFF_FFFF);
    chk("async_out_idle", out_b, 32'hFFFF_FFFF);
    chk("async_src", {27'd0, src_a}, 32'd0);
    chk("async_valid", {31'd0, valid_a | valid_b}, 32'd0);
    chk("async_cont", {31'd0, cont_a | cont_b}, 32'd0);
    chk("async_sticky", {31'd0, sticky_a | sticky_b}, 32'd0);
    chk("async_cnt", {22'd0, cnt_a, cnt_b}, 32'd0);
    step(1'b0, NS'(1) << 7, 1'b0);
    step(1'b0, NS'(1) << 7, 1'b0);
    rand_bus();
    step(1'b1, NS'(1) << 7, 1'b0);

    for (int k = 0; k < 60; k++) begin
      rand_bus();
      step(1'b1, rand_de(), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
